// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and defaults for the boot program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int         c_WORD_W = 32;
    localparam int         c_DEPTH  = 64;
    localparam int         c_ADDR_W = $clog2(c_DEPTH);
    localparam logic [7:0] c_HDR    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_CLEAR = 3'd4,
        ST_DONE  = 3'd5,
        ST_RUN   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/loader_word_asm.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_asm
//  Description : Packs an MSB-first byte stream into 32-bit words. o_word is
//                the completed word, valid together with o_word_valid in the
//                cycle the fourth byte is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    // Shift accepted bytes in and count position within the current word
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[15:0], i_byte_data};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign o_word       = {r_shift, i_byte_data};
    assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Receives a framed byte stream (header, count, words,
//                XOR checksum), writes it into instruction memory, zero-fills
//                the unused tail and releases the core from reset on success.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import loader_pkg::*;
#(
    parameter int         WORD_W = c_WORD_W,
    parameter int         DEPTH  = c_DEPTH,
    parameter int         ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] HDR    = c_HDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    // Counters are one bit wider than the address so they can hold DEPTH.
    localparam logic [ADDR_W:0] c_DEPTH_N = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_is_hdr;
    logic                w_cnt_ok;
    logic                w_csum_ok;
    logic                w_last_word;
    logic                w_asm_clr;
    logic                w_asm_in;
    logic [31:0]         w_word;
    logic                w_word_valid;

    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_widx;
    logic [7:0]          r_csum;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_load_err;

    assign w_accept    = in_valid && w_in_ready;
    assign w_is_hdr    = (in_data == HDR);
    assign w_cnt_ok    = (in_data != 8'd0) && ({24'd0, in_data} <= DEPTH[31:0]);
    assign w_csum_ok   = (in_data == r_csum);
    assign w_last_word = w_word_valid && ((r_widx + c_ONE) == r_count);
    assign w_asm_clr   = w_accept && w_is_hdr && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_asm_in    = w_accept && (r_state == ST_DATA);

    loader_word_asm u_word_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_asm_clr),
        .i_byte_valid (w_asm_in),
        .i_byte_data  (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and byte-acceptance control
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (w_accept && w_is_hdr) w_next = ST_COUNT;
            end
            ST_COUNT: begin
                w_in_ready = 1'b1;
                if (w_accept) w_next = w_cnt_ok ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                w_in_ready = 1'b1;
                if (w_last_word) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    if (!w_csum_ok)              w_next = ST_IDLE;
                    else if (r_count == c_DEPTH_N) w_next = ST_DONE;
                    else                         w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (r_widx == c_DEPTH_N) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                w_in_ready = 1'b1;
                if (w_accept && w_is_hdr) w_next = ST_COUNT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Frame bookkeeping, memory write port and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_widx      <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_load_err  <= 1'b0;
        end else begin
            r_mem_we   <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_asm_clr) begin
                        r_csum <= '0;
                        r_widx <= '0;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        if (w_cnt_ok) r_count    <= in_data[ADDR_W:0];
                        else          r_load_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_accept) r_csum <= r_csum ^ in_data;
                    if (w_word_valid) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_widx[ADDR_W-1:0];
                        r_mem_wdata <= WORD_W'(w_word);
                        r_widx      <= r_widx + c_ONE;
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        if (!w_csum_ok) begin
                            r_load_err <= 1'b1;
                        end else if (r_count != c_DEPTH_N) begin
                            // First zero-fill write issued here so it lands the next cycle
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_count[ADDR_W-1:0];
                            r_mem_wdata <= '0;
                            r_widx      <= r_count + c_ONE;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_widx != c_DEPTH_N) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_widx[ADDR_W-1:0];
                        r_mem_wdata <= '0;
                        r_widx      <= r_widx + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign load_err  = r_load_err;
    assign load_done = (r_state == ST_DONE);
    assign core_rst  = (r_state != ST_RUN);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Directed self-checking bench for program_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cyc[$];
    int          err_cyc[$];
    int          run_cyc[$];
    int          acc4[$];
    logic [31:0] pay[$];
    logic        prev_cr = 1'b1;

    program_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Cycle counter: value seen during a period identifies that period
    always @(posedge clk) cyc <= cyc + 1;

    // Log writes, pulses and core release on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                wr_addr.push_back(int'(mem_addr));
                wr_data.push_back(mem_wdata);
                wr_cyc.push_back(cyc);
            end
            if (load_done) done_cyc.push_back(cyc);
            if (load_err)  err_cyc.push_back(cyc);
            if (prev_cr && !core_rst) run_cyc.push_back(cyc);
        end
        prev_cr <= core_rst;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); err_cyc.delete(); run_cyc.delete();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte; t returns the period in which it was accepted
    task automatic send_byte(input logic [7:0] b, output int t);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("ready_timeout", 64'd0, 64'd1);
        t = cyc;
        @(posedge clk); #1;
    endtask

    // Send a frame built from pay[]; checksum is computed unless forced
    task automatic send_frame(input bit with_hdr, input int n, input bit force_ck,
                              input logic [7:0] ck_val, output int t_ck);
        logic [7:0]  ck;
        logic [31:0] w;
        int          t;
        ck = 8'd0;
        acc4.delete();
        if (with_hdr) send_byte(8'hA5, t);
        send_byte(8'(n), t);
        for (int k = 0; k < n; k++) begin
            w = pay[k];
            for (int b = 3; b >= 0; b--) begin
                ck = ck ^ w[b*8 +: 8];
                send_byte(w[b*8 +: 8], t);
            end
            acc4.push_back(t);
        end
        send_byte(force_ck ? ck_val : ck, t_ck);
        in_valid = 1'b0;
    endtask

    // Verify a successful load of n words with checksum accepted in t_ck
    task automatic check_load(input string tag, input int n, input int t_ck);
        check({tag, "_nwr"},  wr_addr.size(),  64);
        check({tag, "_nerr"}, err_cyc.size(),  0);
        check({tag, "_ndone"}, done_cyc.size(), 1);
        for (int i = 0; i < 64; i++) begin
            if (i < wr_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
                if (i < n) begin
                    check($sformatf("%s_data%0d", tag, i), wr_data[i], pay[i]);
                    check($sformatf("%s_wcyc%0d", tag, i), wr_cyc[i], acc4[i] + 1);
                end else begin
                    check($sformatf("%s_zero%0d", tag, i), wr_data[i], 0);
                    check($sformatf("%s_zcyc%0d", tag, i), wr_cyc[i], t_ck + 1 + (i - n));
                end
            end
        end
        if (done_cyc.size() > 0) begin
            check({tag, "_done_cyc"}, done_cyc[0], t_ck + 64 - n + 1);
            check({tag, "_nrun"}, run_cyc.size(), 1);
            if (run_cyc.size() > 0) check({tag, "_run_cyc"}, run_cyc[0], done_cyc[0] + 1);
        end
        check({tag, "_core_rst"}, core_rst, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, t_ck;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_rst",  core_rst,  1);
        check("rst_mem_we",    mem_we,    0);
        check("rst_mem_addr",  mem_addr,  0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err",  load_err,  0);
        check("rst_busy",      busy,      0);
        check("rst_in_ready",  in_ready,  1);
        rst = 1'b0;
        idle_cycles(2);

        // Two-word frame with correct checksum, zero-fill of 2..63
        clr_logs();
        pay = '{32'h11223344, 32'hAABBCCDD};
        send_frame(1'b1, 2, 1'b0, 8'h00, t_ck);
        idle_cycles(70);
        check_load("two", 2, t_ck);

        // Reload from RUN: header raises core_rst next cycle
        clr_logs();
        check("run_before", core_rst, 0);
        send_byte(8'hA5, t);
        check("reload_core_rst", core_rst, 1);
        check("reload_busy", busy, 1);
        pay = '{32'hDEADBEEF};
        send_frame(1'b0, 1, 1'b0, 8'h00, t_ck);
        idle_cycles(70);
        check_load("reload", 1, t_ck);

        // Bad checksum: error pulse, no zero-fill, core stays in reset
        clr_logs();
        pay = '{32'h11223344, 32'hAABBCCDD};
        send_frame(1'b1, 2, 1'b1, 8'h00, t_ck);
        idle_cycles(70);
        check("badck_nwr", wr_addr.size(), 2);
        check("badck_nerr", err_cyc.size(), 1);
        if (err_cyc.size() > 0) check("badck_err_cyc", err_cyc[0], t_ck + 1);
        check("badck_ndone", done_cyc.size(), 0);
        check("badck_core_rst", core_rst, 1);
        check("badck_busy", busy, 0);
        check("badck_ready", in_ready, 1);

        // Junk bytes ignored, then invalid counts 0 and 65
        clr_logs();
        send_byte(8'h00, t);
        send_byte(8'hFF, t);
        in_valid = 1'b0;
        idle_cycles(2);
        check("junk_busy", busy, 0);
        check("junk_nerr", err_cyc.size(), 0);
        send_byte(8'hA5, t);
        send_byte(8'h00, t);
        in_valid = 1'b0;
        idle_cycles(2);
        check("cnt0_nerr", err_cyc.size(), 1);
        if (err_cyc.size() > 0) check("cnt0_err_cyc", err_cyc[0], t + 1);
        send_byte(8'hA5, t);
        send_byte(8'h41, t);
        in_valid = 1'b0;
        idle_cycles(2);
        check("cnt65_nerr", err_cyc.size(), 2);
        if (err_cyc.size() > 1) check("cnt65_err_cyc", err_cyc[1], t + 1);
        check("cnt_nwr", wr_addr.size(), 0);
        check("cnt_busy", busy, 0);
        check("cnt_core_rst", core_rst, 1);

        // Full 64-word frame, back to back
        clr_logs();
        pay.delete();
        for (int i = 0; i < 64; i++)
            pay.push_back({8'(i), 8'(i + 8'h40), ~8'(i), 8'(i * 3)});
        send_frame(1'b1, 64, 1'b0, 8'h00, t_ck);
        idle_cycles(10);
        check_load("full", 64, t_ck);

        // Reset mid-frame after six payload bytes
        clr_logs();
        pay = '{32'h01020304, 32'h05060708};
        send_byte(8'hA5, t);
        send_byte(8'h02, t);
        for (int b = 3; b >= 0; b--) send_byte(pay[0][b*8 +: 8], t);
        send_byte(8'h05, t);
        send_byte(8'h06, t);
        in_valid = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);
        check("abort_nwr", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            check("abort_addr", wr_addr[0], 0);
            check("abort_data", wr_data[0], 32'h01020304);
        end
        check("abort_nerr", err_cyc.size(), 0);
        check("abort_ndone", done_cyc.size(), 0);
        check("abort_core_rst", core_rst, 1);
        check("abort_busy", busy, 0);

        // A normal frame after the abort
        clr_logs();
        send_frame(1'b1, 2, 1'b0, 8'h00, t_ck);
        idle_cycles(70);
        check_load("after", 2, t_ck);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
